// File: rtl/arb_pkg.sv
// arb_pkg: shared types, sizes and the round-robin search used by rr_arbiter8.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   // Scan the eight positions after `last`, wrapping mod 8; returns {found, idx}.
   // Iterating from the far end down lets the nearest requester overwrite the result.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      found = 1'b0;
      idx   = {IDX_W{1'b0}};
      for (int k = N_REQ; k >= 1; k--) begin
         cand  = last + IDX_W'(k);
         idx   = req[cand] ? cand : idx;
         found = found | req[cand];
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/decoder.sv
// decoder: 3-to-8 one-hot decoder mapping an index to a single set bit.
module decoder (
   input  logic [2:0] sel,
   output logic [7:0] onehot
);

   // Shift one set bit into the selected position
   always_comb begin
      onehot = 8'b0000_0001 << sel;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a rotating pointer and a
// per-grant hold limit; the grant is a registered index expanded to one-hot.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t           state_r, state_nxt_s;
   logic [IDX_W-1:0] idx_r, idx_nxt_s;
   logic [IDX_W-1:0] last_r, last_nxt_s;
   logic [7:0]       hold_r, hold_nxt_s;
   logic [N_REQ-1:0] holder_oh_s;
   logic [N_REQ-1:0] others_s;
   logic [IDX_W:0]   pick_all_s;
   logic [IDX_W:0]   pick_oth_s;

   decoder u_decoder (
      .sel    (idx_r),
      .onehot (holder_oh_s)
   );

   // Candidate winners: full search from idle, holder-excluded search while granted
   always_comb begin
      others_s   = req & ~holder_oh_s;
      pick_all_s = rr_pick(req, last_r);
      pick_oth_s = rr_pick(others_s, last_r);
   end

   // Next-state, next-holder and hold-counter logic
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      last_nxt_s  = last_r;
      hold_nxt_s  = hold_r;
      case (state_r)
         IDLE: begin
            if (pick_all_s[IDX_W]) begin
               state_nxt_s = GRANT;
               idx_nxt_s   = pick_all_s[IDX_W-1:0];
               last_nxt_s  = pick_all_s[IDX_W-1:0];
               hold_nxt_s  = 8'd0;
            end else begin
               hold_nxt_s  = 8'd0;
            end
         end
         GRANT: begin
            if (req[idx_r]) begin
               if (hold_r == HOLD_LAST) begin
                  // At the limit the holder keeps the grant only if nobody else waits
                  if (pick_oth_s[IDX_W]) begin
                     idx_nxt_s  = pick_oth_s[IDX_W-1:0];
                     last_nxt_s = pick_oth_s[IDX_W-1:0];
                  end else begin
                     idx_nxt_s  = idx_r;
                  end
                  hold_nxt_s = 8'd0;
               end else begin
                  hold_nxt_s = hold_r + 8'd1;
               end
            end else if (pick_oth_s[IDX_W]) begin
               idx_nxt_s  = pick_oth_s[IDX_W-1:0];
               last_nxt_s = pick_oth_s[IDX_W-1:0];
               hold_nxt_s = 8'd0;
            end else begin
               state_nxt_s = IDLE;
               hold_nxt_s  = 8'd0;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            hold_nxt_s  = 8'd0;
         end
      endcase
   end

   // Arbitration state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         idx_r   <= 3'd0;
         last_r  <= 3'd7;
         hold_r  <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         last_r  <= last_nxt_s;
         hold_r  <= hold_nxt_s;
      end
   end

   assign gnt_valid = (state_r == GRANT);
   assign gnt_idx   = idx_r;
   assign gnt       = holder_oh_s & {N_REQ{gnt_valid}};

endmodule
